// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a single-clock FIFO and its producer/consumer.
// The master side drives data and requests; the slave side is the FIFO itself.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  Wr_enable;
  logic                  Read_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty_flag;
  logic                  full_flag;
  logic                  almost_empty_flag;
  logic                  almost_full_flag;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow_flag;
  logic                  underflow_flag;

  modport master (
    output data_in, Wr_enable, Read_enable,
    input  data_out, empty_flag, full_flag, almost_empty_flag, almost_full_flag,
    input  count, overflow_flag, underflow_flag
  );

  modport slave (
    input  data_in, Wr_enable, Read_enable,
    output data_out, empty_flag, full_flag, almost_empty_flag, almost_full_flag,
    output count, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable thresholds,
// overflow/underflow pulses and a choice of registered or first-word-fall-through read.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter bit          FWFT          = 1'b0
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullC  = CntW'(AFULL_THRESH);
  localparam logic [CntW-1:0] AemptyC = CntW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  empty_q, full_q, aempty_q, afull_q;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a read on a full FIFO never frees a slot
  // for a write in the same cycle.
  assign wr_acc = bus.Wr_enable && !full_q;
  assign rd_acc = bus.Read_enable && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DepthC);
      aempty_q <= (count_d <= AemptyC);
      afull_q  <= (count_d >= AfullC);
      ovf_q    <= bus.Wr_enable && full_q;
      udf_q    <= bus.Read_enable && empty_q;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= bus.data_in;
  end

  if (FWFT) begin : g_fwft
    assign bus.data_out = mem[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_ptr_q];
      end
    end
    assign bus.data_out = dout_q;
  end

  assign bus.count             = count_q;
  assign bus.empty_flag        = empty_q;
  assign bus.full_flag         = full_q;
  assign bus.almost_empty_flag = aempty_q;
  assign bus.almost_full_flag  = afull_q;
  assign bus.overflow_flag     = ovf_q;
  assign bus.underflow_flag    = udf_q;
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised synchronous FIFO; the same-clock-domain successor to the dual-clock FIFO. It buffers DATA_WIDTH-bit words, depth 2**ADDR_WIDTH, between a producer and consumer sharing `clk`. Additions over the dual-clock block:
- occupancy count
- programmable almost-full/almost-empty thresholds
- overflow/underflow error pulses
- selectable standard or first-word-fall-through (FWFT) read mode

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits (≥1)
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH (≥2)
- AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full_flag asserted when count ≥ this (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty_flag asserted when count ≤ this (0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH  write data, sampled when a write is accepted
- Wr_enable  in  1  write request
- Read_enable  in  1  read request (FWFT=1: pop/acknowledge of the head word)
- data_out  out  DATA_WIDTH  read data
- empty_flag  out  1  count == 0
- full_flag  out  1  count == DEPTH
- almost_empty_flag  out  1  count ≤ AEMPTY_THRESH
- almost_full_flag  out  1  count ≥ AFULL_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow_flag  out  1  one-cycle pulse: write rejected
- underflow_flag  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH-entry array, not reset.
- Pointers: wr_ptr and rd_ptr, ADDR_WIDTH bits each. Both wrap from DEPTH-1 to 0 (natural binary wrap).
- Count register: ADDR_WIDTH+1 bits. Full/empty derive from count, not pointer compare.
- Write accepted iff Wr_enable && !full_flag: mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted iff Read_enable && !empty_flag: rd_ptr increments.
- Acceptance uses flag values from before the edge. A simultaneous read on a full FIFO does not free a slot for a same-cycle write; that write is rejected.
- Count next value: +1 on write only, −1 on read only, unchanged on both or neither.
- All flags are registered and computed from next count, so they are consistent with count every cycle.
- overflow_flag is high for exactly one cycle after each edge where Wr_enable && full_flag. underflow_flag is the same for Read_enable && empty_flag. A rejected operation changes no state.
- FWFT=0: on an accepted read, data_out <= mem[rd_ptr] (registered). Otherwise data_out holds its last value.
- FWFT=1: data_out = mem[rd_ptr] (combinational from the array) whenever empty_flag==0. When empty it is don't-care and the bench must not check it. An accepted read advances to the next word.
- Reset (rst=1 at an edge), including mid-operation:
  - wr_ptr, rd_ptr, count = 0
  - empty_flag = 1, almost_empty_flag = 1
  - full_flag = 0, almost_full_flag = 0, overflow_flag = 0, underflow_flag = 0
  - data_out = 0 (FWFT=0)
  - Wr_enable and Read_enable are ignored in that cycle. Stored data is logically discarded.

## Timing
- Write-to-empty_flag deassert: 1 cycle (the flag falls on the accepting edge).
- FWFT=0 read latency: data appears on the edge that accepts the read. Write-to-first-readable: write at edge N, read request at edge N+1 earliest, data valid after edge N+1.
- FWFT=1: head word is visible on data_out after the edge that writes it into an empty FIFO.
- Sustained throughput: 1 write and 1 read per cycle, count steady.
- No combinational path from Wr_enable/Read_enable to any flag or count.

## Test plan
1. Reset, then Read_enable=1 for 1 cycle on empty FIFO -> underflow_flag pulses 1 cycle, count stays 0, empty_flag stays 1.
2. Write 8 then 9; read 2 (FWFT=0) -> data_out 8 then 9; count 1,2,1,0; empty_flag returns 1.
3. Write 0..31 (ADDR_WIDTH=5):
   - full_flag rises on the 32nd accepted write, count = 32.
   - almost_full_flag rises at count = 30; almost_empty_flag falls at count = 3.
   - A 33rd write with data 0xAA -> overflow_flag pulse; a subsequent full read-out returns 0..31 with no 0xAA.
4. Fill to 32, then hold Wr_enable=Read_enable=1 for 40 cycles with incrementing data -> reads proceed; writes are accepted only on cycles where full_flag is low at the edge; output sequence is strictly in write order with no duplicates or losses.
5. Pointer wrap: 3 rounds of write 20 / read 20 -> data intact across the 31->0 wrap, count returns to 0 each round.
6. Write 10 words, assert rst for 1 cycle with Wr_enable=1 -> count 0, empty_flag 1, nothing written. Repeat with FWFT=1: after writing 0x5A into an empty FIFO, data_out = 0x5A before any read.
